// File: rtl/rtc_cmd_pkg.sv
// rtl/rtc_cmd_pkg.sv - opcodes, payload lengths, state and error encodings for the RTC command loader
package rtc_cmd_pkg;

    localparam logic [7:0] OP_SET_TIME  = 8'h01;
    localparam logic [7:0] OP_SET_CAL   = 8'h02;
    localparam logic [7:0] OP_SET_ALARM = 8'h03;
    localparam logic [7:0] OP_ALARM_EN  = 8'h04;

    localparam logic [2:0] LEN_SET_TIME  = 3'd3;
    localparam logic [2:0] LEN_SET_CAL   = 3'd5;
    localparam logic [2:0] LEN_SET_ALARM = 3'd4;
    localparam logic [2:0] LEN_ALARM_EN  = 3'd1;

    localparam logic [1:0] ERR_OPCODE  = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    // A zero length marks an opcode the loader does not recognise.
    function automatic logic [2:0] payload_len(input logic [7:0] op);
        case (op)
            OP_SET_TIME:  payload_len = LEN_SET_TIME;
            OP_SET_CAL:   payload_len = LEN_SET_CAL;
            OP_SET_ALARM: payload_len = LEN_SET_ALARM;
            OP_ALARM_EN:  payload_len = LEN_ALARM_EN;
            default:      payload_len = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/rtc_field_check.sv
// rtl/rtc_field_check.sv - combinational range validator for decoded command fields
// Only the leading four payload bytes carry range-checked fields; the year bytes are never checked.
module rtc_field_check
    import rtc_cmd_pkg::*;
(
    input  logic [7:0]      opcode,
    input  logic [3:0][7:0] fields,
    output logic            pass
);

    always_comb begin
        pass = 1'b0;
        case (opcode)
            OP_SET_TIME:  pass = (fields[0] <= 8'd23) && (fields[1] <= 8'd59) && (fields[2] <= 8'd59);
            OP_SET_CAL:   pass = (fields[0] >= 8'd1) && (fields[0] <= 8'd31) &&
                                 (fields[1][3:0] <= 4'd6) &&
                                 (fields[2] >= 8'd1) && (fields[2] <= 8'd12);
            // Alarm day 0 means any day, weekday 7 means any weekday.
            OP_SET_ALARM: pass = (fields[0] <= 8'd23) && (fields[1] <= 8'd59) &&
                                 (fields[2] <= 8'd31) && (fields[3] <= 8'd7);
            OP_ALARM_EN:  pass = 1'b1;
            default:      pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/rtc_cmd_loader.sv
// rtl/rtc_cmd_loader.sv - byte-stream command decoder driving the RTC set buses
module rtc_cmd_loader
    import rtc_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int TO_W        = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        set_time,
    output logic        set_cal,
    output logic [23:0] set_full_time,
    output logic [35:0] set_full_cal,
    output logic [27:0] set_alarm_time,
    output logic        intr_alarm,
    output logic        err,
    output logic [1:0]  err_code
);

    state_t          state;
    logic [7:0]      opcode;
    logic [2:0]      idx;
    logic [4:0][7:0] pay_buf;
    logic [TO_W-1:0] to_cnt;
    logic            accept;
    logic            checks_ok;

    assign in_ready = (state != ST_COMMIT);
    assign accept   = in_valid && in_ready;

    rtc_field_check u_field_check (
        .opcode (opcode),
        .fields (pay_buf[3:0]),
        .pass   (checks_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            opcode         <= 8'h00;
            idx            <= 3'd0;
            pay_buf        <= '0;
            to_cnt         <= '0;
            set_time       <= 1'b0;
            set_cal        <= 1'b0;
            set_full_time  <= '0;
            set_full_cal   <= '0;
            set_alarm_time <= '0;
            intr_alarm     <= 1'b0;
            err            <= 1'b0;
            err_code       <= 2'b00;
        end else begin
            set_time <= 1'b0;
            set_cal  <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (payload_len(in_data) != 3'd0) begin
                            opcode <= in_data;
                            idx    <= 3'd0;
                            to_cnt <= '0;
                            state  <= ST_PAYLOAD;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_OPCODE;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        pay_buf[idx] <= in_data;
                        idx          <= idx + 3'd1;
                        to_cnt       <= '0;
                        if (idx == payload_len(opcode) - 3'd1)
                            state <= ST_COMMIT;
                    end else if (to_cnt >= TO_W'(TIMEOUT_CYC - 1)) begin
                        // Parked at the limit so a stalled command never wraps the counter.
                        to_cnt   <= TO_W'(TIMEOUT_CYC);
                        state    <= ST_IDLE;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                    if (checks_ok) begin
                        case (opcode)
                            OP_SET_TIME: begin
                                set_full_time <= {pay_buf[0], pay_buf[1], pay_buf[2]};
                                set_time      <= 1'b1;
                            end
                            OP_SET_CAL: begin
                                set_full_cal <= {pay_buf[0], pay_buf[1][3:0], pay_buf[2],
                                                 pay_buf[3], pay_buf[4]};
                                set_cal      <= 1'b1;
                            end
                            OP_SET_ALARM:
                                set_alarm_time <= {pay_buf[0], pay_buf[1], pay_buf[2], pay_buf[3][3:0]};
                            default:
                                intr_alarm <= pay_buf[0][0];
                        endcase
                    end else begin
                        err      <= 1'b1;
                        err_code <= ERR_RANGE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
